// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD counter.
//   bcd_digit_t : one 4-bit BCD digit
//   BCD_MAX     : largest legal digit value (9)
//   BCD_MIN     : smallest legal digit value (0)
//   bcd_sat()   : clamps a raw nibble into the legal BCD range
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_counter_digit_cell.sv
// Combinational next-value logic for one BCD digit.
// Ports:
//   cur       : current digit value
//   dir       : 1 = increment, 0 = decrement
//   carry_in  : request to change this digit
//   next      : digit value after the (possible) change
//   carry_out : request to change the next higher digit (this digit wrapped)
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t cur,
  input  logic       dir,
  input  logic       carry_in,
  output bcd_digit_t next,
  output logic       carry_out
);

  always_comb begin
    next      = cur;
    carry_out = 1'b0;
    if (carry_in) begin
      if (dir) begin
        if (cur >= BCD_MAX) begin
          next      = BCD_MIN;
          carry_out = 1'b1;
        end else begin
          next = cur + 4'd1;
        end
      end else begin
        if (cur == BCD_MIN) begin
          next      = BCD_MAX;
          carry_out = 1'b1;
        end else begin
          next = cur - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with step prescaler, parallel load,
// synchronous clear and a one-cycle rollover pulse. All outputs are registered.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   enable         : advances the prescaler
//   count_up       : 1 = increment, 0 = decrement on a step
//   clear          : synchronous clear of count and prescaler (highest priority)
//   load           : synchronous parallel load (nibbles above 9 stored as 9)
//   load_value     : load data, digit 0 in bits [3:0]
//   digits         : current count, digit 0 least significant
//   rollover_flag  : high for the cycle after a full-range wrap
//   step_tick      : high for the cycle after each applied step
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    count_up,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    rollover_flag,
  output logic                    step_tick
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0]             presc;
  logic [4*NUM_DIGITS-1:0] digits_next;
  logic [4*NUM_DIGITS-1:0] load_sat;
  logic [NUM_DIGITS:0]     carry;

  // Digit 0 always receives the change request; the chain decides the rest.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .cur       (digits[4*i +: 4]),
      .dir       (count_up),
      .carry_in  (carry[i]),
      .next      (digits_next[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  always_comb begin
    load_sat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_sat[4*i +: 4] = bcd_sat(load_value[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits        <= '0;
      presc         <= '0;
      rollover_flag <= 1'b0;
      step_tick     <= 1'b0;
    end else begin
      rollover_flag <= 1'b0;
      step_tick     <= 1'b0;
      if (clear) begin
        digits <= '0;
        presc  <= '0;
      end else if (load) begin
        digits <= load_sat;
        presc  <= '0;
      end else if (enable) begin
        if (presc == PRESCALE_LAST) begin
          presc         <= '0;
          digits        <= digits_next;
          step_tick     <= 1'b1;
          // Carry out of the top digit means every digit wrapped.
          rollover_flag <= carry[NUM_DIGITS];
        end else begin
          presc <= presc + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
module tb_bcd_counter;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic        r;
    logic        t;
  } exp_t;

  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic rst = 1'b1;

  logic        en1 = 0, up1 = 1, clr1 = 0, ld1 = 0;
  logic [15:0] lv1 = '0;
  logic [15:0] dig1;
  logic        roll1, tick1;

  logic        en4 = 0, up4 = 1, clr4 = 0, ld4 = 0;
  logic [15:0] lv4 = '0;
  logic [15:0] dig4;
  logic        roll4, tick4;

  int checks = 0;
  int errors = 0;

  exp_t q1[$];
  exp_t q4[$];

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  bcd_counter #(.NUM_DIGITS(4), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .enable(en1), .count_up(up1), .clear(clr1),
    .load(ld1), .load_value(lv1), .digits(dig1),
    .rollover_flag(roll1), .step_tick(tick1)
  );

  bcd_counter #(.NUM_DIGITS(4), .PRESCALE(4)) dut_p4 (
    .clk(clk), .rst(rst), .enable(en4), .count_up(up4), .clear(clr4),
    .load(ld4), .load_value(lv4), .digits(dig4),
    .rollover_flag(roll4), .step_tick(tick4)
  );

  task automatic compare(input exp_t e, input logic [15:0] d, input logic r, input logic t);
    checks++;
    if (d !== e.d || r !== e.r || t !== e.t) begin
      errors++;
      $display("FAIL %s: got digits=%h roll=%b tick=%b, expected digits=%h roll=%b tick=%b",
               e.name, d, r, t, e.d, e.r, e.t);
    end
  endtask

  // Monitors: one pending expectation is consumed per falling edge.
  always @(negedge clk) begin
    if (q1.size() > 0) compare(q1.pop_front(), dig1, roll1, tick1);
  end

  always @(negedge clk) begin
    if (q4.size() > 0) compare(q4.pop_front(), dig4, roll4, tick4);
  end

  task automatic cyc1(input string nm, input logic en, input logic up, input logic clr,
                      input logic ld, input logic [15:0] lv,
                      input logic [15:0] ed, input logic er, input logic et);
    exp_t e;
    en1 = en; up1 = up; clr1 = clr; ld1 = ld; lv1 = lv;
    @(posedge clk);
    #1;
    e.name = nm; e.d = ed; e.r = er; e.t = et;
    q1.push_back(e);
  endtask

  task automatic cyc4(input string nm, input logic en, input logic up, input logic clr,
                      input logic ld, input logic [15:0] lv,
                      input logic [15:0] ed, input logic er, input logic et);
    exp_t e;
    en4 = en; up4 = up; clr4 = clr; ld4 = ld; lv4 = lv;
    @(posedge clk);
    #1;
    e.name = nm; e.d = ed; e.r = er; e.t = et;
    q4.push_back(e);
  endtask

  task automatic direct(input string nm, input logic [15:0] d, input logic r, input logic t);
    exp_t e;
    e.name = nm; e.d = 16'h0000; e.r = 1'b0; e.t = 1'b0;
    compare(e, d, r, t);
  endtask

  initial begin
    #2;
    direct("reset_p1", dig1, roll1, tick1);
    direct("reset_p4", dig4, roll4, tick4);
    @(negedge clk);
    rst = 1'b0;

    // PRESCALE=1: up count with carry chain
    cyc1("idle",        0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    cyc1("load_0998",   0, 1, 0, 1, 16'h0998, 16'h0998, 0, 0);
    cyc1("up_0999",     1, 1, 0, 0, 16'h0000, 16'h0999, 0, 1);
    cyc1("up_1000",     1, 1, 0, 0, 16'h0000, 16'h1000, 0, 1);
    cyc1("up_1001",     1, 1, 0, 0, 16'h0000, 16'h1001, 0, 1);
    // up wrap; load with enable shows load wins
    cyc1("load_9999",   1, 1, 0, 1, 16'h9999, 16'h9999, 0, 0);
    cyc1("up_wrap",     1, 1, 0, 0, 16'h0000, 16'h0000, 1, 1);
    cyc1("wrap_hold",   0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    // down wrap and borrow chain
    cyc1("load_0000",   0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
    cyc1("down_wrap",   1, 0, 0, 0, 16'h0000, 16'h9999, 1, 1);
    cyc1("dwrap_hold",  0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0);
    cyc1("load_1000",   0, 0, 0, 1, 16'h1000, 16'h1000, 0, 0);
    cyc1("down_0999",   1, 0, 0, 0, 16'h0000, 16'h0999, 0, 1);
    cyc1("dir_up",      1, 1, 0, 0, 16'h0000, 16'h1000, 0, 1);
    cyc1("dir_down",    1, 0, 0, 0, 16'h0000, 16'h0999, 0, 1);
    // priority and sanitising
    cyc1("clr_and_ld",  1, 1, 1, 1, 16'h4321, 16'h0000, 0, 0);
    cyc1("load_00fa",   0, 1, 0, 1, 16'h00FA, 16'h0099, 0, 0);
    cyc1("up_0100",     1, 1, 0, 0, 16'h0000, 16'h0100, 0, 1);
    cyc1("load_5a3c",   0, 1, 0, 1, 16'h5A3C, 16'h5939, 0, 0);
    cyc1("load_9000",   0, 1, 0, 1, 16'h9000, 16'h9000, 0, 0);
    cyc1("clr_only",    1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0);

    // async reset with clock stopped, while flags are high
    cyc1("pre_9999",    0, 1, 0, 1, 16'h9999, 16'h9999, 0, 0);
    cyc1("pre_wrap",    1, 1, 0, 0, 16'h0000, 16'h0000, 1, 1);
    cyc1("pre_0001",    1, 1, 0, 0, 16'h0000, 16'h0001, 0, 1);
    en1 = 0;
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    direct("async_rst", dig1, roll1, tick1);
    #4;
    rst = 1'b0;
    #2;
    clk_run = 1'b1;
    cyc1("post_rst",    0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);

    // PRESCALE=4
    cyc4("p4_load",     0, 1, 0, 1, 16'h0000, 16'h0000, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc4($sformatf("p4_en%0d", k), 1, 1, 0, 0, 16'h0000,
           (k < 4) ? 16'h0000 : ((k < 8) ? 16'h0001 : 16'h0002), 0, (k == 4 || k == 8));
    end
    for (int k = 1; k <= 3; k++) cyc4($sformatf("p4_off%0d", k), 0, 1, 0, 0, 16'h0000, 16'h0002, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc4($sformatf("p4_resume%0d", k), 1, 1, 0, 0, 16'h0000,
           (k < 4) ? 16'h0002 : 16'h0003, 0, (k == 4));
    end
    cyc4("p4_pre_a",    1, 1, 0, 0, 16'h0000, 16'h0003, 0, 0);
    cyc4("p4_pre_b",    1, 1, 0, 0, 16'h0000, 16'h0003, 0, 0);
    cyc4("p4_ld_en",    1, 1, 0, 1, 16'h0050, 16'h0050, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc4($sformatf("p4_restart%0d", k), 1, 1, 0, 0, 16'h0000,
           (k < 4) ? 16'h0050 : 16'h0051, 0, (k == 4));
    end
    for (int k = 1; k <= 3; k++) cyc4($sformatf("p4_pre_c%0d", k), 1, 1, 0, 0, 16'h0000, 16'h0051, 0, 0);
    cyc4("p4_clr_ld",   1, 1, 1, 1, 16'h7777, 16'h0000, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc4($sformatf("p4_after_clr%0d", k), 1, 0, 0, 0, 16'h0000,
           (k < 4) ? 16'h0000 : 16'h9999, (k == 4), (k == 4));
    end
    en4 = 0;

    repeat (3) @(posedge clk);
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL drain: pending q1=%0d q4=%0d, expected 0 and 0", q1.size(), q4.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Multi-digit synchronous BCD up/down counter with a programmable step prescaler, parallel load, clear, and a one-cycle rollover pulse.
- Sits directly upstream of the per-digit seven-segment decoders; each registered output digit feeds one decoder's 4-bit value input.
- Decoders are fed with carry_in tied low, because all carry resolution happens inside this block.

Parameters:
- NUM_DIGITS, 4: number of BCD digits (1..8).
- PRESCALE, 1: enabled clock cycles per count step (1..65535); 1 means one step per enabled cycle.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  advances the prescaler when high.
- count_up  input  1  1 = increment, 0 = decrement; sampled on the step cycle.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous parallel load.
- load_value  input  4*NUM_DIGITS  load data; digit 0 is in bits [3:0].
- digits  output  4*NUM_DIGITS  current count; digit 0 is the least significant.
- rollover_flag  output  1  one-cycle pulse on full-range wrap.
- step_tick  output  1  one-cycle pulse, high on the cycle a step is applied.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values while rst is high:
  - digits = 0
  - rollover_flag = 0
  - step_tick = 0
  - prescaler = 0
- Reset asserted mid-operation overrides everything immediately, with no clock required.
- Prescaler:
  - Counts enabled cycles from 0 to PRESCALE-1.
  - A step occurs on the enabled cycle in which the prescaler equals PRESCALE-1; on that cycle the prescaler returns to 0.
  - With enable low, the prescaler holds.
  - With PRESCALE=1, every enabled cycle is a step.
- Priority per clock edge:
  - clear > load > step > hold.
  - Clear: digits = 0, prescaler = 0, no flags.
  - Load: digits = load_value, prescaler = 0, no flags.
  - A step suppressed by clear or load is lost; step_tick stays low that cycle.
- Load sanitising: any loaded nibble above 9 is stored as 9. Illegal BCD never appears on digits.
- Count up on a step:
  - Digit 0 increments.
  - Digit i increments only if all lower digits are 9.
  - A digit at 9 that increments becomes 0.
- Count down on a step:
  - Digit 0 decrements.
  - Digit i decrements only if all lower digits are 0.
  - A digit at 0 that decrements becomes 9.
- Rollover:
  - rollover_flag is registered and high for exactly the cycle after the edge on which the count wrapped.
  - Up wrap: all 9s -> all 0s. Down wrap: all 0s -> all 9s.
  - It is coincident with the first cycle the wrapped value is visible on digits.
- step_tick:
  - Registered; high for the single cycle following each applied step.
  - Aligned with the updated digits.
- Latency: one clock from step decision to new digits.
- Internal arithmetic:
  - Per-digit 4-bit values with 1-bit carry/borrow chains.
  - No binary-to-BCD conversion; no combinational path from inputs to outputs.
- Direction changes take effect on the next step with no extra delay.
- Simultaneous enable and load: load wins and the prescaler restarts at 0.

Decomposition:
- Shared package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0])
  - constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0
  - function bcd_sat(nibble), which clamps to 9
- Sub-module bcd_digit_cell, one per digit via a generate loop:
  - Inputs: cur digit, dir, carry_in (increment/decrement request).
  - Outputs: next digit, carry_out (request to the next digit).
  - The top level chains carry_out to carry_in and registers the results.

Test Plan:
- Reset / async: rst pulsed mid-count with clk stopped -> digits = 0000 and flags = 0 immediately.
- Up count with carry chain:
  - Stimulus: PRESCALE=1, load 0x0998, count_up=1, enable=1 for 3 cycles.
  - Required: digits 0999, then 1000, then 1001; step_tick high each cycle; rollover_flag stays 0.
- Up wrap: load 0x9999, one step up -> digits = 0000 with rollover_flag high for exactly 1 cycle.
- Down wrap / borrow chain:
  - load 0x0000, one step down -> digits = 9999 with a rollover_flag pulse.
  - load 0x1000, one step down -> 0999 with no flag.
- Prescaler:
  - Stimulus: PRESCALE=4, enable high for 8 cycles, then low for 3, then high.
  - Required: exactly 2 steps during the first 8 cycles (step_tick on the 4th and 8th); no steps while enable is low; the next step comes 4 enabled cycles later.
- Priority / sanitising:
  - clear and load asserted together on a step cycle -> digits = 0000, no step_tick.
  - load 0x00FA -> digits = 0x0099.
  - load and step on the same cycle -> loaded value held and prescaler restarts.
